mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 214 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and a req/ack data memory.
// Handles lane selection, alignment checking, load extension and an ack timeout.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        MemW,
  input  logic        MemtoReg,
  input  logic [1:0]  Load_size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [4:0]  Rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        res_valid,
  output logic [4:0]  Rd_out,
  output logic [31:0] ReadData,
  output logic        misalign,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        res_valid_q, res_valid_d;
  logic [4:0]  rd_out_q, rd_out_d;
  logic [31:0] read_data_q, read_data_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  logic        is_mem_op;
  logic        misaligned;
  logic [3:0]  be_acc;
  logic [31:0] wdata_acc;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;

  // Request decode: byte enables and lane-replicated store data for the incoming op.
  always_comb begin
    is_mem_op  = MemW || MemtoReg;
    misaligned = ((Load_size == 2'd0) && (Addr[1:0] != 2'b00)) ||
                 ((Load_size == 2'd1) && Addr[0]) ||
                 (Load_size == 2'd3);
    case (Load_size)
      2'd0: begin
        be_acc    = 4'b1111;
        wdata_acc = WriteData;
      end
      2'd1: begin
        be_acc    = 4'b0011 << {Addr[1], 1'b0};
        wdata_acc = {2{WriteData[15:0]}};
      end
      default: begin
        be_acc    = 4'b0001 << Addr[1:0];
        wdata_acc = {4{WriteData[7:0]}};
      end
    endcase
  end

  // Load data: pick the addressed lane from the ack beat and extend it.
  always_comb begin
    byte_lane = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_lane = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'd0:    load_ext = mem_rdata;
      2'd1:    load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
      default: load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    res_valid_d = 1'b0;
    rd_out_d    = rd_out_q;
    read_data_d = read_data_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    rd_d        = rd_q;
    addr_lo_d   = addr_lo_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d     = Load_size;
          unsigned_d = Unsigned;
          rd_d       = Rd;
          addr_lo_d  = Addr[1:0];
          if (is_mem_op) begin
            if (misaligned) begin
              misalign_d = 1'b1;
            end else begin
              state_d     = ACCESS;
              cnt_d       = 8'd0;
              mem_req_d   = 1'b1;
              mem_we_d    = MemW;
              mem_addr_d  = {Addr[31:2], 2'b00};
              mem_be_d    = be_acc;
              mem_wdata_d = wdata_acc;
            end
          end
        end
      end
      ACCESS: begin
        // Ack is checked first so a last-cycle ack still completes normally.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            state_d     = RESP;
            res_valid_d = 1'b1;
            read_data_d = load_ext;
            rd_out_d    = rd_q;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
      res_valid_q <= 1'b0;
      rd_out_q    <= 5'd0;
      read_data_q <= 32'd0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
      size_q      <= 2'd0;
      unsigned_q  <= 1'b0;
      rd_q        <= 5'd0;
      addr_lo_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      res_valid_q <= res_valid_d;
      rd_out_q    <= rd_out_d;
      read_data_q <= read_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
      size_q      <= size_d;
      unsigned_q  <= unsigned_d;
      rd_q        <= rd_d;
      addr_lo_q   <= addr_lo_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign res_valid = res_valid_q;
  assign Rd_out    = rd_out_q;
  assign ReadData  = read_data_q;
  assign misalign  = misalign_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with TIMEOUT=4; expected values are hand-derived.
module tb_mem_access_unit;

  logic        CLK;
  logic        RESETn;
  logic        req_valid;
  logic        req_ready;
  logic        MemW;
  logic        MemtoReg;
  logic [1:0]  Load_size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [4:0]  Rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic [4:0]  Rd_out;
  logic [31:0] ReadData;
  logic        misalign;
  logic        bus_err;
  logic        busy;

  int checkCount = 0;
  int failCount  = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .MemW(MemW), .MemtoReg(MemtoReg), .Load_size(Load_size), .Unsigned(Unsigned),
    .Addr(Addr), .WriteData(WriteData), .Rd(Rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .Rd_out(Rd_out), .ReadData(ReadData),
    .misalign(misalign), .bus_err(bus_err), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    checkCount++;
    if (got !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, expected);
    end
  endtask

  // Presents one request at a negedge; returns at the next negedge with it accepted.
  task automatic applyStimulus(input logic mw, input logic mtr, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1;
    MemW      = mw;
    MemtoReg  = mtr;
    Load_size = size;
    Unsigned  = uns;
    Addr      = addr;
    WriteData = wd;
    Rd        = rd;
    @(negedge CLK);
    req_valid = 1'b0;
    MemW      = 1'b0;
    MemtoReg  = 1'b0;
  endtask

  task automatic ackWith(input logic [31:0] data);
    mem_ack   = 1'b1;
    mem_rdata = data;
    @(negedge CLK);
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
  endtask

  initial begin
    int reqCycles;
    RESETn = 1'b0; req_valid = 1'b0; MemW = 1'b0; MemtoReg = 1'b0;
    Load_size = 2'd0; Unsigned = 1'b0; Addr = 32'd0; WriteData = 32'd0; Rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;

    repeat (2) @(negedge CLK);
    checkOutput("reset_mem_req",   {31'd0, mem_req}, 32'd0);
    checkOutput("reset_mem_addr",  mem_addr, 32'd0);
    checkOutput("reset_mem_be",    {28'd0, mem_be}, 32'd0);
    checkOutput("reset_readdata",  ReadData, 32'd0);
    checkOutput("reset_flags",     {28'd0, res_valid, misalign, bus_err, busy}, 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Signed byte load from the top lane.
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h0000_0103, 32'd0, 5'd7);
    checkOutput("lb_mem_req",   {31'd0, mem_req}, 32'd1);
    checkOutput("lb_mem_be",    {28'd0, mem_be}, 32'h8);
    checkOutput("lb_mem_addr",  mem_addr, 32'h0000_0100);
    checkOutput("lb_we_ready",  {30'd0, mem_we, req_ready}, 32'd0);
    ackWith(32'h8000_0000);
    checkOutput("lb_res_valid", {31'd0, res_valid}, 32'd1);
    checkOutput("lb_readdata",  ReadData, 32'hFFFF_FF80);
    checkOutput("lb_rd_out",    {27'd0, Rd_out}, 32'd7);
    checkOutput("lb_mem_req_drop", {31'd0, mem_req}, 32'd0);
    @(negedge CLK);
    checkOutput("lb_res_one_cycle", {31'd0, res_valid}, 32'd0);
    checkOutput("lb_ready_again", {31'd0, req_ready}, 32'd1);

    // Back-to-back signed half load from the upper half.
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'd0, 5'd3);
    checkOutput("lh_mem_be", {28'd0, mem_be}, 32'hC);
    ackWith(32'h8001_0000);
    checkOutput("lh_readdata", ReadData, 32'hFFFF_8001);
    @(negedge CLK);

    // Half store replicated into both halves.
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 5'd0);
    checkOutput("sh_mem_be",    {28'd0, mem_be}, 32'hC);
    checkOutput("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
    checkOutput("sh_mem_we",    {31'd0, mem_we}, 32'd1);
    checkOutput("sh_mem_addr",  mem_addr, 32'h0000_0200);
    ackWith(32'h0);
    checkOutput("sh_done", {29'd0, res_valid, mem_req, busy}, 32'd0);
    @(negedge CLK);
    checkOutput("sh_no_res", {31'd0, res_valid}, 32'd0);

    // MemW and MemtoReg together: treated as a word store.
    applyStimulus(1'b1, 1'b1, 2'd0, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 5'd9);
    checkOutput("sw_we_req",  {30'd0, mem_we, mem_req}, 32'd3);
    checkOutput("sw_wdata",   mem_wdata, 32'hCAFE_F00D);
    checkOutput("sw_be",      {28'd0, mem_be}, 32'hF);
    ackWith(32'h0);
    checkOutput("sw_no_res",  {30'd0, res_valid, busy}, 32'd0);

    // Misaligned word load.
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'd0, 5'd1);
    checkOutput("mis_pulse",  {31'd0, misalign}, 32'd1);
    checkOutput("mis_no_req", {30'd0, mem_req, busy}, 32'd0);
    checkOutput("mis_ready",  {31'd0, req_ready}, 32'd1);
    @(negedge CLK);
    checkOutput("mis_once",   {30'd0, misalign, mem_req}, 32'd0);

    // Reserved size is misaligned regardless of address.
    applyStimulus(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 5'd0);
    checkOutput("rsv_misalign", {30'd0, misalign, mem_req}, 32'h2);
    @(negedge CLK);

    // No-op request and a stray ack in IDLE.
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0400, 32'd0, 5'd0);
    checkOutput("noop_idle", {28'd0, mem_req, misalign, busy, req_ready}, 32'd1);
    ackWith(32'hFFFF_FFFF);
    checkOutput("stray_ack", {29'd0, res_valid, busy, bus_err}, 32'd0);

    // Timeout: ack withheld, TIMEOUT=4.
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0040, 32'd0, 5'd2);
    reqCycles = 0;
    while (mem_req && reqCycles < 20) begin
      reqCycles++;
      @(negedge CLK);
    end
    checkOutput("to_req_cycles", reqCycles, 32'd4);
    checkOutput("to_bus_err",    {31'd0, bus_err}, 32'd1);
    checkOutput("to_state",      {29'd0, mem_req, res_valid, busy}, 32'd0);
    @(negedge CLK);
    checkOutput("to_once",       {30'd0, bus_err, res_valid}, 32'd0);

    // Unsigned half load with a delayed ack; request must stay stable.
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, 32'h0000_0010, 32'd0, 5'd4);
    for (int i = 0; i < 3; i++) begin
      checkOutput("lhu_hold_ctl",  {26'd0, mem_req, mem_we, mem_be}, 32'h23);
      checkOutput("lhu_hold_addr", mem_addr, 32'h0000_0010);
      if (i < 2) @(negedge CLK);
    end
    ackWith(32'h0000_F00F);
    checkOutput("lhu_readdata", ReadData, 32'h0000_F00F);
    checkOutput("lhu_res",      {31'd0, res_valid}, 32'd1);
    @(negedge CLK);

    // Ack arriving in the same cycle the timeout would fire.
    applyStimulus(1'b0, 1'b1, 2'd2, 1'b1, 32'h0000_0001, 32'd0, 5'd5);
    repeat (3) @(negedge CLK);
    ackWith(32'h0000_A500);
    checkOutput("race_res_err", {30'd0, res_valid, bus_err}, 32'h2);
    checkOutput("race_readdata", ReadData, 32'h0000_00A5);
    @(negedge CLK);

    // Reset asserted mid-ACCESS.
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0080, 32'd0, 5'd6);
    checkOutput("rst_pre_req", {31'd0, mem_req}, 32'd1);
    #2 RESETn = 1'b0;
    #1;
    checkOutput("rst_async_ctl",  {29'd0, mem_req, mem_we, busy}, 32'd0);
    checkOutput("rst_async_addr", mem_addr, 32'd0);
    checkOutput("rst_async_be",   {28'd0, mem_be}, 32'd0);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      checkOutput("rst_quiet", {29'd0, res_valid, bus_err, busy}, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0084, 32'd0, 5'd11);
    checkOutput("rst_new_req", {31'd0, mem_req}, 32'd1);
    ackWith(32'hDEAD_BEEF);
    checkOutput("rst_new_res",  {31'd0, res_valid}, 32'd1);
    checkOutput("rst_new_data", ReadData, 32'hDEAD_BEEF);
    checkOutput("rst_new_rd",   {27'd0, Rd_out}, 32'd11);
    @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
